// File: rtl/sprite_multi.sv
// sprite_multi: multi-sprite overlay engine.
// Holds NUM_SPRITES bitmaps with per-sprite position, power-of-two scale,
// flip and colour-key transparency. Every pixel goes through a fixed
// six-register pipeline. The lowest-index opaque sprite wins.
module sprite_multi #(
  parameter int    NUM_SPRITES        = 4,
  parameter int    SPRITE_WIDTH_BITS  = 6,
  parameter int    SPRITE_HEIGHT_BITS = 7,
  parameter int    BPP                = 8,
  parameter int    OFFSET_BITS        = 16,
  parameter int    SCALE_DIV_BITS     = 8,
  parameter string RAM_TYPE           = "auto"
) (
  input  logic                clk,
  input  logic                reset,
  output logic [31:0]         bitmap_length,
  input  logic [31:0]         bitmap_address,
  input  logic [BPP-1:0]      bitmap_din,
  input  logic                bitmap_we,
  input  logic                attr_we,
  input  logic [7:0]          attr_index,
  input  logic [2:0]          attr_addr,
  input  logic [31:0]         attr_din,
  input  logic                frame_start,
  input  logic                pixel_valid,
  input  logic signed [31:0]  count_h,
  input  logic signed [31:0]  count_v,
  output logic                color_valid,
  output logic [BPP-1:0]      color,
  output logic                hit,
  output logic [7:0]          hit_index
);

  localparam int N     = NUM_SPRITES;
  localparam int WB    = SPRITE_WIDTH_BITS;
  localparam int HB    = SPRITE_HEIGHT_BITS;
  localparam int A     = WB + HB;
  localparam int D     = OFFSET_BITS + 16;
  localparam int DEPTH = 1 << A;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  // Address bits above the sprite index and attribute bits above the field
  // widths carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{bitmap_address[31:A+8], attr_din[31:OFFSET_BITS]};

  assign bitmap_length = 32'(DEPTH);

  // Attribute sets: the CPU writes the shadow set and frame_start publishes it.
  logic signed [OFFSET_BITS-1:0] sh_x [N], sh_y [N], act_x [N], act_y [N];
  logic [3:0]     sh_scale [N], act_scale [N];
  logic [2:0]     sh_ctrl [N], act_ctrl [N];
  logic [BPP-1:0] sh_key [N], act_key [N];
  logic [IW-1:0]  aidx;

  assign aidx = attr_index[IW-1:0];

  // Pipeline state, one lane per sprite.
  logic                 v1, v2, v3, v4, v5;
  logic signed [D-1:0]  dx0 [N], dy0 [N], dx1 [N], dy1 [N];
  logic [3:0]           sc1 [N];
  logic [2:0]           ctl1 [N], ctl2 [N];
  logic [BPP-1:0]       key1 [N], key2 [N], key3 [N], key4 [N], key5 [N];
  logic                 in3 [N], in4 [N], in5 [N];
  logic [A-1:0]         addr3 [N];
  logic [BPP-1:0]       rd_data [N];

  logic                 win_hit;
  logic [7:0]           win_idx;
  logic [BPP-1:0]       win_color;

  // Shadow attribute writes; out-of-range sprite or field selects are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_scale[i] <= 4'd0;
        sh_ctrl[i]  <= 3'd0;
        sh_key[i]   <= '0;
      end
    end else if (attr_we && (int'(attr_index) < N)) begin
      case (attr_addr)
        3'd0:    sh_x[aidx]     <= attr_din[OFFSET_BITS-1:0];
        3'd1:    sh_y[aidx]     <= attr_din[OFFSET_BITS-1:0];
        3'd2:    sh_scale[aidx] <= attr_din[3:0];
        3'd3:    sh_ctrl[aidx]  <= attr_din[2:0];
        3'd4:    sh_key[aidx]   <= attr_din[BPP-1:0];
        default: ;
      endcase
    end
  end

  // Publish the pre-write shadow set to the active set at frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        act_x[i]     <= '0;
        act_y[i]     <= '0;
        act_scale[i] <= 4'd0;
        act_ctrl[i]  <= 3'd0;
        act_key[i]   <= '0;
      end
    end else if (frame_start) begin
      act_x     <= sh_x;
      act_y     <= sh_y;
      act_scale <= sh_scale;
      act_ctrl  <= sh_ctrl;
      act_key   <= sh_key;
    end
  end

  // Stage 1: raster-relative offsets. The attributes used by later stages are
  // latched here so that pixels already in flight keep the old attribute set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        dx0[i]  <= '0;
        dy0[i]  <= '0;
        sc1[i]  <= 4'd0;
        ctl1[i] <= 3'd0;
        key1[i] <= '0;
      end
    end else begin
      v1 <= pixel_valid;
      for (int i = 0; i < N; i++) begin
        dx0[i]  <= D'(count_h) - D'(act_x[i]);
        dy0[i]  <= D'(count_v) - D'(act_y[i]);
        sc1[i]  <= act_scale[i];
        ctl1[i] <= act_ctrl[i];
        key1[i] <= act_key[i];
      end
    end
  end

  // Stage 2: power-of-two scaling with an arithmetic right shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        dx1[i]  <= '0;
        dy1[i]  <= '0;
        ctl2[i] <= 3'd0;
        key2[i] <= '0;
      end
    end else begin
      v2 <= v1;
      for (int i = 0; i < N; i++) begin
        dx1[i]  <= (dx0[i] <<< sc1[i]) >>> SCALE_DIV_BITS;
        dy1[i]  <= (dy0[i] <<< sc1[i]) >>> SCALE_DIV_BITS;
        ctl2[i] <= ctl1[i];
        key2[i] <= key1[i];
      end
    end
  end

  // Stage 3: bounds test and bitmap address. The upper bits must be zero for
  // 0 <= d < size, and flipping a coordinate is its bitwise inverse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        in3[i]   <= 1'b0;
        addr3[i] <= '0;
        key3[i]  <= '0;
      end
    end else begin
      v3 <= v2;
      for (int i = 0; i < N; i++) begin
        in3[i]   <= ctl2[i][0] && (dx1[i][D-1:WB] == '0) && (dy1[i][D-1:HB] == '0);
        addr3[i] <= {(ctl2[i][2] ? ~dy1[i][HB-1:0] : dy1[i][HB-1:0]),
                     (ctl2[i][1] ? ~dx1[i][WB-1:0] : dx1[i][WB-1:0])};
        key3[i]  <= key2[i];
      end
    end
  end

  // Per-sprite bitmap RAMs: write port from the CPU side, and a read port
  // with a registered address and registered data.
  for (genvar s = 0; s < N; s++) begin : g_ram
    logic           we;
    logic [A-1:0]   rd_addr;
    logic [BPP-1:0] rd_q;

    assign we         = bitmap_we && (bitmap_address[A+7:A] == 8'(s));
    assign rd_data[s] = rd_q;

    if (RAM_TYPE == "auto") begin : g_inferred
      logic [BPP-1:0] mem [DEPTH];
      // Read-before-write bitmap storage, left to the tool to map
      always_ff @(posedge clk) begin
        if (we) mem[bitmap_address[A-1:0]] <= bitmap_din;
        rd_addr <= addr3[s];
        rd_q    <= mem[rd_addr];
      end
    end else begin : g_styled
      (* ram_style = RAM_TYPE *) logic [BPP-1:0] mem [DEPTH];
      // Read-before-write bitmap storage with the requested RAM style
      always_ff @(posedge clk) begin
        if (we) mem[bitmap_address[A-1:0]] <= bitmap_din;
        rd_addr <= addr3[s];
        rd_q    <= mem[rd_addr];
      end
    end
  end

  // Stages 4-5: carry the inside flag and key alongside the RAM read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v4 <= 1'b0;
      v5 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        in4[i]  <= 1'b0;
        in5[i]  <= 1'b0;
        key4[i] <= '0;
        key5[i] <= '0;
      end
    end else begin
      v4 <= v3;
      v5 <= v4;
      for (int i = 0; i < N; i++) begin
        in4[i]  <= in3[i];
        in5[i]  <= in4[i];
        key4[i] <= key3[i];
        key5[i] <= key4[i];
      end
    end
  end

  // Priority resolve: scan from high to low so that the lowest opaque index wins
  always_comb begin
    win_hit   = 1'b0;
    win_idx   = 8'd0;
    win_color = '0;
    for (int i = N - 1; i >= 0; i--) begin
      win_color = (in5[i] && (rd_data[i] != key5[i])) ? rd_data[i] : win_color;
      win_idx   = (in5[i] && (rd_data[i] != key5[i])) ? 8'(i)      : win_idx;
      win_hit   = (in5[i] && (rd_data[i] != key5[i])) ? 1'b1       : win_hit;
    end
  end

  // Stage 6: registered outputs, held at zero whenever no pixel is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_valid <= 1'b0;
      color       <= '0;
      hit         <= 1'b0;
      hit_index   <= 8'd0;
    end else begin
      color_valid <= v5;
      color       <= (v5 && win_hit) ? win_color : '0;
      hit         <= v5 && win_hit;
      hit_index   <= (v5 && win_hit) ? win_idx : 8'd0;
    end
  end

endmodule

// File: tb/tb_sprite_multi.sv
// Bench for sprite_multi: table-driven pixel vectors per attribute setup,
// scoreboard queue aligned to the six-cycle pipeline, plus hand sequences
// for shadow/frame_start timing and asynchronous reset.
module tb_sprite_multi;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        bitmap_length;
  logic [31:0]        bitmap_address;
  logic [7:0]         bitmap_din;
  logic               bitmap_we;
  logic               attr_we;
  logic [7:0]         attr_index;
  logic [2:0]         attr_addr;
  logic [31:0]        attr_din;
  logic               frame_start;
  logic               pixel_valid;
  logic signed [31:0] count_h;
  logic signed [31:0] count_v;
  logic               color_valid;
  logic [7:0]         color;
  logic               hit;
  logic [7:0]         hit_index;

  always #5 clk = ~clk;

  sprite_multi dut (
    .clk(clk), .reset(reset), .bitmap_length(bitmap_length),
    .bitmap_address(bitmap_address), .bitmap_din(bitmap_din), .bitmap_we(bitmap_we),
    .attr_we(attr_we), .attr_index(attr_index), .attr_addr(attr_addr), .attr_din(attr_din),
    .frame_start(frame_start), .pixel_valid(pixel_valid),
    .count_h(count_h), .count_v(count_v),
    .color_valid(color_valid), .color(color), .hit(hit), .hit_index(hit_index)
  );

  typedef struct { logic valid; logic [7:0] color; logic hit; logic [7:0] idx; } exp_t;
  typedef struct { int cfg; int h; int v; logic [7:0] color; logic hit; logic [7:0] idx; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  exp_t idle_e = '{1'b0, 8'd0, 1'b0, 8'd0};

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: record what the currently driven inputs should produce, then
  // compare the output due from the entry driven six cycles earlier.
  task automatic tick(exp_t e);
    exp_t f;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() >= 6) begin
      f = sb.pop_front();
      check("color_valid", 32'(color_valid), 32'(f.valid));
      check("color", 32'(color), 32'(f.color));
      check("hit", 32'(hit), 32'(f.hit));
      check("hit_index", 32'(hit_index), 32'(f.idx));
    end
  endtask

  task automatic prefill();
    sb.delete();
    for (int i = 0; i < 5; i++) sb.push_back(idle_e);
  endtask

  task automatic px(int h, int v, int c, int ht, int ix);
    exp_t e;
    pixel_valid = 1'b1;
    count_h = h;
    count_v = v;
    e = '{1'b1, 8'(c), 1'(ht), 8'(ix)};
    tick(e);
    pixel_valid = 1'b0;
  endtask

  task automatic attr(int idx, int addr, logic [31:0] data);
    attr_we = 1'b1; attr_index = 8'(idx); attr_addr = 3'(addr); attr_din = data;
    tick(idle_e);
    attr_we = 1'b0;
  endtask

  task automatic bm(int addr, int data);
    bitmap_we = 1'b1; bitmap_address = 32'(addr); bitmap_din = 8'(data);
    tick(idle_e);
    bitmap_we = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(idle_e);
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) tick(idle_e);
  endtask

  task automatic configure(int c);
    logic [31:0] x, y;
    logic [31:0] sc, ct, k0, ct1;
    x = 32'd10; y = 32'd20; sc = 32'd8; ct = 32'd1; k0 = 32'hFF; ct1 = 32'd0;
    case (c)
      2:       begin k0 = 32'd1; ct1 = 32'd1; end
      3:       sc = 32'd9;
      4:       sc = 32'd7;
      5:       ct = 32'd3;
      6:       ct = 32'd5;
      7:       begin x = 32'h1234_FFFB; y = 32'h0001_0014; end
      default: ;
    endcase
    attr(0, 0, x); attr(0, 1, y); attr(0, 2, sc); attr(0, 3, ct); attr(0, 4, k0);
    attr(1, 0, 32'd10); attr(1, 1, 32'd20); attr(1, 2, 32'd8); attr(1, 3, ct1); attr(1, 4, 32'hFE);
    attr(5, 3, 32'd1);   // sprite 5 does not exist
    attr(0, 7, 32'd0);   // field 7 does not exist
    frame();
  endtask

  task automatic add(int cfg, int h, int v, int c, int ht, int ix);
    vec_t e;
    e.cfg = cfg; e.h = h; e.v = v; e.color = 8'(c); e.hit = 1'(ht); e.idx = 8'(ix);
    tbl.push_back(e);
  endtask

  initial begin
    int cur;
    // cfg 1: sprite 0 at (10,20) 1:1, key 0xFF; bitmap0[k]=k&0xFF
    for (int h = 10; h <= 73; h++) add(1, h, 20, h - 10, 1, 0);
    add(1, 9, 20, 0, 0, 0);    add(1, 74, 20, 0, 0, 0);
    add(1, 10, 21, 64, 1, 0);  add(1, 73, 23, 0, 0, 0);
    add(1, 72, 23, 254, 1, 0); add(1, 10, 19, 0, 0, 0);
    add(1, 10, 147, 192, 1, 0); add(1, 10, 148, 0, 0, 0);
    // cfg 2: sprite 1 enabled on top, sprite 0 key=1; bitmap1[k]=(k+100)&0xFF
    add(2, 10, 20, 0, 1, 0);   add(2, 11, 20, 101, 1, 1);
    add(2, 12, 20, 2, 1, 0);   add(2, 9, 20, 0, 0, 0);
    add(2, 73, 23, 255, 1, 0); add(2, 11, 21, 65, 1, 0);
    // cfg 3: scale 9 doubles the offset
    add(3, 10, 20, 0, 1, 0);   add(3, 11, 20, 2, 1, 0);
    add(3, 41, 20, 62, 1, 0);  add(3, 42, 20, 0, 0, 0);
    add(3, 10, 21, 128, 1, 0);
    // cfg 4: scale 7 halves the offset
    add(4, 10, 20, 0, 1, 0);   add(4, 11, 20, 0, 1, 0);
    add(4, 12, 20, 1, 1, 0);   add(4, 13, 20, 1, 1, 0);
    add(4, 137, 20, 63, 1, 0); add(4, 138, 20, 0, 0, 0);
    add(4, 9, 20, 0, 0, 0);    add(4, 10, 275, 192, 1, 0);
    // cfg 5: hflip; cfg 6: vflip
    add(5, 10, 20, 63, 1, 0);  add(5, 73, 20, 0, 1, 0);  add(5, 11, 21, 126, 1, 0);
    add(6, 10, 20, 192, 1, 0); add(6, 12, 21, 130, 1, 0); add(6, 10, 148, 0, 0, 0);
    // cfg 7: x=-5 after truncation, y=20 after truncation
    add(7, 0, 20, 5, 1, 0);    add(7, -5, 20, 0, 1, 0);
    add(7, -6, 20, 0, 0, 0);   add(7, 58, 20, 63, 1, 0);  add(7, 59, 20, 0, 0, 0);

    reset = 1'b0; bitmap_address = 32'd0; bitmap_din = 8'd0; bitmap_we = 1'b0;
    attr_we = 1'b0; attr_index = 8'd0; attr_addr = 3'd0; attr_din = 32'd0;
    frame_start = 1'b0; pixel_valid = 1'b0; count_h = 32'sd0; count_v = 32'sd0;

    #7;
    check("reset_color_valid", 32'(color_valid), 32'd0);
    check("reset_color", 32'(color), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_hit_index", 32'(hit_index), 32'd0);
    check("bitmap_length", bitmap_length, 32'd8192);
    @(negedge clk);
    reset = 1'b1;
    prefill();

    for (int k = 0; k < 8192; k++) bm(k, k & 255);
    for (int k = 0; k < 8192; k++) bm((1 << 13) | k, (k + 100) & 255);
    bm((4 << 13) | 0, 8'hAA);  // sprite 4 does not exist
    bm((5 << 13) | 1, 8'hAB);  // sprite 5 does not exist

    cur = 0;
    foreach (tbl[i]) begin
      if (tbl[i].cfg != cur) begin
        drain();
        configure(tbl[i].cfg);
        cur = tbl[i].cfg;
      end
      px(tbl[i].h, tbl[i].v, tbl[i].color, tbl[i].hit, tbl[i].idx);
    end
    drain();

    // Shadow writes stay invisible until frame_start
    attr(0, 0, 32'd10); frame();
    px(10, 20, 0, 1, 0);
    attr(0, 0, 32'd100);
    px(10, 20, 0, 1, 0); px(11, 20, 1, 1, 0); px(100, 20, 0, 0, 0);
    // frame_start with a coinciding write: active takes the pre-write value,
    // and the pixel sampled on the same edge still uses the old set
    attr_we = 1'b1; attr_index = 8'd0; attr_addr = 3'd0; attr_din = 32'd200;
    frame_start = 1'b1;
    px(11, 20, 1, 1, 0);
    attr_we = 1'b0; frame_start = 1'b0;
    px(101, 20, 1, 1, 0); px(201, 20, 0, 0, 0);
    frame_start = 1'b1;
    px(101, 20, 1, 1, 0);
    frame_start = 1'b0;
    px(201, 20, 1, 1, 0); px(200, 20, 0, 1, 0);

    // Asynchronous reset in the middle of a hitting scan
    for (int k = 0; k < 8; k++) px(200 + k, 20, k, 1, 0);
    check("pre_reset_color_valid", 32'(color_valid), 32'd1);
    pixel_valid = 1'b1; count_h = 32'sd210; count_v = 32'sd20;
    #2 reset = 1'b0;
    #1;
    check("rst_color_valid", 32'(color_valid), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_index", 32'(hit_index), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_color_valid", 32'(color_valid), 32'd0);
    check("rst_hold_hit", 32'(hit), 32'd0);
    reset = 1'b1;
    pixel_valid = 1'b0;
    prefill();
    px(10, 20, 0, 0, 0);       // all sprites disabled after reset
    px(11, 20, 0, 0, 0);
    attr(0, 0, 32'd10); attr(0, 1, 32'd20); attr(0, 2, 32'd8);
    attr(0, 3, 32'd1); attr(0, 4, 32'hFF);
    px(10, 21, 0, 0, 0);       // still disabled until frame_start
    frame();
    px(10, 21, 64, 1, 0); px(11, 20, 1, 1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
